// File: rtl/ysyx_23060240_clint_timer_if.sv
// AXI4 single-beat bus bundle between the crossbar's clint_* master port and the CLINT timer slave.
interface ysyx_23060240_clint_timer_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst, rready,
           awaddr, awvalid, awid, awlen, awsize, awburst,
           wdata, wstrb, wvalid, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, rid,
           awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
           awaddr, awvalid, awid, awlen, awsize, awburst,
           wdata, wstrb, wvalid, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, rid,
           awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/ysyx_23060240_clint_timer.sv
// CLINT timer AXI4 slave: free-running 64-bit mtime with coherent hi shadow, optional mtimecmp/mtip.
// Define CLINT_MTIMECMP_EN to build mtimecmp storage and the mtip compare; otherwise mtip is tied 0.
module ysyx_23060240_clint_timer #(
  parameter logic [31:0] BASE = 32'ha0000048,
  parameter logic [3:0]  BID  = 4'h0
) (
  input  logic                              clk,
  input  logic                              rst,
  ysyx_23060240_clint_timer_if.slave        axi,
  output logic                              mtip
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
`ifdef CLINT_MTIMECMP_EN
  localparam logic [1:0] CMP_WR_RESP = RESP_OKAY;
`else
  localparam logic [1:0] CMP_WR_RESP = RESP_SLVERR;
`endif

  typedef enum logic {R_IDLE, R_DATA} rState_e;
  typedef enum logic {W_IDLE, W_RESP} wState_e;

  rState_e     rState_q, rState_d;
  wState_e     wState_q, wState_d;
  logic [63:0] mtime_q;
  logic [63:0] cmpView;
  logic [31:0] hiShadow_q, hiShadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] rdOff;

  logic        awGot_q, awGot_d, wGot_q, wGot_d;
  logic [31:0] awAddr_q, awAddr_d, wData_q, wData_d;
  logic [3:0]  awId_q, awId_d, wStrb_q, wStrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [3:0]  bid_q, bid_d;
  logic        awFire, wFire, doWrite;
  logic [31:0] awAddrEff, wDataEff, wOff;
  logic [3:0]  awIdEff, wStrbEff;
  logic [1:0]  wrResp;
  logic        cmpWrLo, cmpWrHi;

  function automatic logic inWindow(input logic [31:0] off);
    return (off[31:4] == 28'd0) && (off[1:0] == 2'b00);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) mtime_q <= 64'd0;
    else     mtime_q <= mtime_q + 64'd1;
  end

  // Read FSM: a lo-word read snapshots mtime[63:32] so a following hi read is coherent.
  always_comb begin
    rState_d   = rState_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rid_d      = rid_q;
    hiShadow_d = hiShadow_q;
    rdOff      = axi.araddr - BASE;
    case (rState_q)
      R_IDLE: begin
        if (axi.arvalid) begin
          rState_d = R_DATA;
          rid_d    = axi.arid;
          if (!inWindow(rdOff)) begin
            rdata_d = 32'd0;
            rresp_d = RESP_DECERR;
          end else begin
            rresp_d = RESP_OKAY;
            case (rdOff[3:2])
              2'b00: begin
                rdata_d    = mtime_q[31:0];
                hiShadow_d = mtime_q[63:32];
              end
              2'b01:   rdata_d = hiShadow_q;
              2'b10:   rdata_d = cmpView[31:0];
              default: rdata_d = cmpView[63:32];
            endcase
          end
        end
      end
      R_DATA: begin
        if (axi.rready) rState_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rState_q   <= R_IDLE;
      rdata_q    <= 32'd0;
      rresp_q    <= 2'b00;
      rid_q      <= 4'd0;
      hiShadow_q <= 32'd0;
    end else begin
      rState_q   <= rState_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rid_q      <= rid_d;
      hiShadow_q <= hiShadow_d;
    end
  end

  assign awFire    = (wState_q == W_IDLE) && !awGot_q && axi.awvalid;
  assign wFire     = (wState_q == W_IDLE) && !wGot_q && axi.wvalid;
  assign doWrite   = (wState_q == W_IDLE) && (awGot_q || awFire) && (wGot_q || wFire);
  assign awAddrEff = awGot_q ? awAddr_q : axi.awaddr;
  assign awIdEff   = awGot_q ? awId_q   : axi.awid;
  assign wDataEff  = wGot_q  ? wData_q  : axi.wdata;
  assign wStrbEff  = wGot_q  ? wStrb_q  : axi.wstrb;
  assign wOff      = awAddrEff - BASE;
  assign cmpWrLo   = doWrite && inWindow(wOff) && (wOff[3:2] == 2'b10);
  assign cmpWrHi   = doWrite && inWindow(wOff) && (wOff[3:2] == 2'b11);

  always_comb begin
    wrResp = RESP_SLVERR;
    if (!inWindow(wOff)) wrResp = RESP_DECERR;
    else if (wOff[3])    wrResp = CMP_WR_RESP;
  end

  // Write FSM: AW and W are latched independently; the write commits the cycle both are present.
  always_comb begin
    wState_d = wState_q;
    awGot_d  = awGot_q;
    wGot_d   = wGot_q;
    awAddr_d = awAddr_q;
    awId_d   = awId_q;
    wData_d  = wData_q;
    wStrb_d  = wStrb_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    case (wState_q)
      W_IDLE: begin
        if (doWrite) begin
          wState_d = W_RESP;
          awGot_d  = 1'b0;
          wGot_d   = 1'b0;
          bid_d    = awIdEff;
          bresp_d  = wrResp;
        end else begin
          if (awFire) begin
            awGot_d  = 1'b1;
            awAddr_d = axi.awaddr;
            awId_d   = axi.awid;
          end
          if (wFire) begin
            wGot_d  = 1'b1;
            wData_d = axi.wdata;
            wStrb_d = axi.wstrb;
          end
        end
      end
      W_RESP: begin
        if (axi.bready) wState_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wState_q <= W_IDLE;
      awGot_q  <= 1'b0;
      wGot_q   <= 1'b0;
      awAddr_q <= 32'd0;
      awId_q   <= 4'd0;
      wData_q  <= 32'd0;
      wStrb_q  <= 4'd0;
      bresp_q  <= 2'b00;
      bid_q    <= 4'd0;
    end else begin
      wState_q <= wState_d;
      awGot_q  <= awGot_d;
      wGot_q   <= wGot_d;
      awAddr_q <= awAddr_d;
      awId_q   <= awId_d;
      wData_q  <= wData_d;
      wStrb_q  <= wStrb_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
    end
  end

`ifdef CLINT_MTIMECMP_EN
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        mtip_q;

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (cmpWrLo) mtimecmp_d[31:0]  = mergeBytes(mtimecmp_q[31:0], wDataEff, wStrbEff);
    if (cmpWrHi) mtimecmp_d[63:32] = mergeBytes(mtimecmp_q[63:32], wDataEff, wStrbEff);
  end

  // mtip compares the pre-update registers, so a new mtimecmp shows up one cycle after it lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtip_q     <= 1'b0;
    end else begin
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  assign cmpView = mtimecmp_q;
  assign mtip    = mtip_q;
`else
  logic unusedCmpPath;
  assign unusedCmpPath = ^{wDataEff, wStrbEff, cmpWrLo, cmpWrHi};
  assign cmpView       = 64'd0;
  assign mtip          = 1'b0;
`endif

  logic unusedAttrs;
  assign unusedAttrs = ^{axi.arlen, axi.arsize, axi.arburst, axi.awlen, axi.awsize,
                         axi.awburst, axi.wlast, BID};

  assign axi.arready = (rState_q == R_IDLE);
  assign axi.rvalid  = (rState_q == R_DATA);
  assign axi.rlast   = (rState_q == R_DATA);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rid     = rid_q;
  assign axi.awready = (wState_q == W_IDLE) && !awGot_q;
  assign axi.wready  = (wState_q == W_IDLE) && !wGot_q;
  assign axi.bvalid  = (wState_q == W_RESP);
  assign axi.bresp   = bresp_q;
  assign axi.bid     = bid_q;

endmodule

// File: tb/tb_ysyx_23060240_clint_timer.sv
// Scoreboard bench for the CLINT timer: stimulus pushes expected R/B beats, a monitor pops on handshakes.
module tb_ysyx_23060240_clint_timer;
  localparam logic [31:0] BASE = 32'ha0000048;
`ifdef CLINT_MTIMECMP_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mtip;
  ysyx_23060240_clint_timer_if axi();

  ysyx_23060240_clint_timer #(.BASE(BASE), .BID(4'h0)) dut (
    .clk  (clk),
    .rst  (rst),
    .axi  (axi),
    .mtip (mtip)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; logic [3:0] id; } rExp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bExp_t;

  rExp_t       rQ[$];
  bExp_t       bQ[$];
  int          vectorsApplied = 0;
  int          miscompares    = 0;
  logic [63:0] modelTime = 64'd0;
  logic [63:0] modelCmp  = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [31:0] modelHi   = 32'd0;
  logic        expMtip   = 1'b0;
  bit          monOn     = 1'b0;

  // Reference counter and interrupt: mtime counts from release of reset, mtip lags the compare by one cycle.
  always @(posedge clk) begin
    if (rst) begin
      modelTime <= 64'd0;
      expMtip   <= 1'b0;
    end else begin
      modelTime <= modelTime + 64'd1;
      expMtip   <= EN && (modelTime >= modelCmp);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    vectorsApplied++;
    miscompares++;
    $display("[TB] FAIL %s: got no response, expected one", name);
  endtask

  // Monitor: samples just after each negedge, when inputs for the coming edge are settled.
  initial begin
    rExp_t re;
    bExp_t be;
    forever begin
      @(negedge clk);
      #2;
      if (monOn) begin
        checkOutput("mtip", mtip, expMtip);
        if (axi.rvalid && axi.rready) begin
          if (rQ.size() == 0) reportFail("r_unexpected");
          else begin
            re = rQ.pop_front();
            checkOutput("rdata", axi.rdata, re.data);
            checkOutput("rresp", axi.rresp, re.resp);
            checkOutput("rid", axi.rid, re.id);
            checkOutput("rlast", axi.rlast, 1);
          end
        end
        if (axi.bvalid && axi.bready) begin
          if (bQ.size() == 0) reportFail("b_unexpected");
          else begin
            be = bQ.pop_front();
            checkOutput("bresp", axi.bresp, be.resp);
            checkOutput("bid", axi.bid, be.id);
          end
        end
      end
    end
  end

  // Called and returns at a negedge; the R handshake is pending at the next posedge on return.
  task automatic applyStimulusRead(input logic [31:0] addr, input logic [3:0] id, input int stall);
    rExp_t       e;
    logic [31:0] off;
    for (int g = 0; g < 20 && !axi.arready; g++) @(negedge clk);
    if (!axi.arready) begin
      reportFail("arready_timeout");
      return;
    end
    off = addr - BASE;
    e.id = id;
    if (off[31:4] != 28'd0 || off[1:0] != 2'b00) begin
      e.data = 32'd0;
      e.resp = 2'b11;
    end else begin
      e.resp = 2'b00;
      case (off[3:2])
        2'b00: begin
          e.data  = modelTime[31:0];
          modelHi = modelTime[63:32];
        end
        2'b01:   e.data = modelHi;
        2'b10:   e.data = EN ? modelCmp[31:0]  : 32'd0;
        default: e.data = EN ? modelCmp[63:32] : 32'd0;
      endcase
    end
    rQ.push_back(e);
    axi.araddr  = addr;
    axi.arid    = id;
    axi.arvalid = 1'b1;
    axi.rready  = (stall == 0);
    @(negedge clk);
    axi.arvalid = 1'b0;
    checkOutput("rvalid_latency", axi.rvalid, 1);
    for (int i = 0; i < stall; i++) begin
      checkOutput("rvalid_hold", axi.rvalid, 1);
      checkOutput("rdata_hold", axi.rdata, e.data);
      @(negedge clk);
    end
    axi.rready = 1'b1;
  endtask

  // lead > 0: W goes lead cycles before AW; lead < 0: AW first; 0: same cycle.
  task automatic applyStimulusWrite(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb, input logic [3:0] id, input int lead);
    bExp_t       e;
    logic [31:0] off;
    int          wStart, awStart;
    bit          wDone, awDone, wHs, awHs;
    wStart  = (lead < 0) ? -lead : 0;
    awStart = (lead > 0) ? lead : 0;
    wDone = 0; awDone = 0; wHs = 0; awHs = 0;
    off = addr - BASE;
    e.id = id;
    if (off[31:4] != 28'd0 || off[1:0] != 2'b00) e.resp = 2'b11;
    else if (off[3])                               e.resp = EN ? 2'b00 : 2'b10;
    else                                           e.resp = 2'b10;
    bQ.push_back(e);
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (wHs)  begin axi.wvalid  = 1'b0; wDone  = 1; wHs  = 0; end
      if (awHs) begin axi.awvalid = 1'b0; awDone = 1; awHs = 0; end
      if (wDone && awDone) break;
      if (!wDone && cyc >= wStart) begin
        axi.wvalid = 1'b1;
        axi.wdata  = data;
        axi.wstrb  = strb;
        wHs        = axi.wready;
      end
      if (!awDone && cyc >= awStart) begin
        axi.awvalid = 1'b1;
        axi.awaddr  = addr;
        axi.awid    = id;
        awHs        = axi.awready;
      end
    end
    if (!(wDone && awDone)) begin
      reportFail("write_handshake_timeout");
      axi.wvalid  = 1'b0;
      axi.awvalid = 1'b0;
      return;
    end
    checkOutput("bvalid_latency", axi.bvalid, 1);
    if (EN && e.resp == 2'b00) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) begin
          if (off[2]) modelCmp[32 + 8*i +: 8] = data[8*i +: 8];
          else        modelCmp[8*i +: 8]      = data[8*i +: 8];
        end
      end
    end
  endtask

  initial begin
    axi.araddr = '0; axi.arvalid = 1'b0; axi.arid = '0; axi.arlen = '0; axi.arsize = 3'd2;
    axi.arburst = 2'b01; axi.rready = 1'b1;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.awid = '0; axi.awlen = '0; axi.awsize = 3'd2;
    axi.awburst = 2'b01; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.wlast = 1'b1;
    axi.bready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_arready", axi.arready, 1);
    checkOutput("rst_awready", axi.awready, 1);
    checkOutput("rst_wready", axi.wready, 1);
    checkOutput("rst_rvalid", axi.rvalid, 0);
    checkOutput("rst_bvalid", axi.bvalid, 0);
    checkOutput("rst_rdata", axi.rdata, 0);
    checkOutput("rst_rresp", axi.rresp, 0);
    checkOutput("rst_rlast", axi.rlast, 0);
    checkOutput("rst_rid", axi.rid, 0);
    checkOutput("rst_bresp", axi.bresp, 0);
    checkOutput("rst_bid", axi.bid, 0);
    checkOutput("rst_mtip", mtip, 0);
    rst   = 1'b0;
    monOn = 1'b1;

    applyStimulusRead(BASE + 32'h4, 4'h1, 0);
    while (modelTime < 64'd10) @(negedge clk);
    applyStimulusRead(BASE, 4'h5, 3);
    applyStimulusRead(BASE + 32'h4, 4'h6, 0);
    applyStimulusRead(BASE + 32'h8, 4'h7, 0);
    applyStimulusRead(BASE + 32'hC, 4'h8, 0);
    applyStimulusRead(BASE + 32'h10, 4'h9, 0);
    applyStimulusRead(BASE + 32'h2, 4'hA, 0);
    applyStimulusRead(BASE - 32'h4, 4'hB, 0);

    applyStimulusWrite(BASE + 32'h8, 32'h0000_0100, 4'hF, 4'h1, 2);
    applyStimulusWrite(BASE + 32'hC, 32'h0000_0000, 4'hF, 4'h2, 2);
    for (int g = 0; g < 1000 && modelTime < 64'h110; g++) @(negedge clk);
    checkOutput("mtip_after_cmp", mtip, EN ? 1 : 0);

    applyStimulusWrite(BASE + 32'h8, 32'hAABB_CCDD, 4'b0010, 4'h3, 0);
    applyStimulusRead(BASE + 32'h8, 4'hC, 0);
    applyStimulusWrite(BASE, 32'h1234_5678, 4'hF, 4'h4, -1);
    applyStimulusRead(BASE, 4'hD, 0);
    applyStimulusWrite(BASE + 32'h4, 32'h0, 4'hF, 4'h5, 1);
    applyStimulusWrite(BASE + 32'h14, 32'h0, 4'hF, 4'h6, 0);

    // Abort a read mid-response with reset; the dropped beat never reaches the scoreboard.
    @(negedge clk);
    for (int g = 0; g < 20 && !axi.arready; g++) @(negedge clk);
    axi.araddr  = BASE;
    axi.arid    = 4'h3;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b0;
    @(negedge clk);
    axi.arvalid = 1'b0;
    checkOutput("rvalid_before_rst", axi.rvalid, 1);
    rst      = 1'b1;
    modelCmp = 64'hFFFF_FFFF_FFFF_FFFF;
    modelHi  = 32'd0;
    @(negedge clk);
    checkOutput("midrst_rvalid", axi.rvalid, 0);
    checkOutput("midrst_arready", axi.arready, 1);
    checkOutput("midrst_rdata", axi.rdata, 0);
    checkOutput("midrst_rid", axi.rid, 0);
    rst = 1'b0;
    applyStimulusRead(BASE, 4'h1, 0);
    applyStimulusRead(BASE + 32'h4, 4'h2, 0);
    applyStimulusRead(BASE + 32'h8, 4'h4, 0);

    for (int g = 0; g < 10 && (rQ.size() != 0 || bQ.size() != 0); g++) @(negedge clk);
    if (rQ.size() != 0 || bQ.size() != 0) reportFail("scoreboard_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end
endmodule
